// File: rtl/fpu_wb_queue.sv
// FPU write-back queue: canonicalizing FIFO between FPU results and the FP register-file write port.
// Optional FPU_WB_BYPASS_EN: zero-latency pass-through of in_* to out_* when the queue is empty.
module fpu_wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [4:0]               out_rd,
  output logic [4:0]               fflags,
  input  logic                     fflags_clr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [4:0]  flags;
  } entry_t;

  // Any NaN collapses to the canonical quiet NaN; everything else passes unchanged.
  function automatic logic [31:0] canon(input logic [31:0] d);
    if ((d[30:23] == 8'hFF) && (d[22:0] != 23'd0)) return 32'h7FC0_0000;
    return d;
  endfunction

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      fflags_q;
  entry_t          in_ent;
  entry_t          head;
  logic            bypass;
  logic            deq;
  logic            push;
  logic            pop;

  always_comb begin
    in_ent       = '0;
    in_ent.data  = canon(in_data);
    in_ent.rd    = in_rd;
    in_ent.flags = in_flags;
  end

`ifdef FPU_WB_BYPASS_EN
  assign bypass = (cnt_q == '0) && in_valid;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready  = cnt_q < CW'(DEPTH);
  assign out_valid = (cnt_q != '0) || bypass;
  assign head      = bypass ? in_ent : mem[rd_ptr];
  assign deq       = out_valid && out_ready;
  assign pop       = deq && !bypass;
  // A bypassed entry consumed in the same cycle is never written to storage.
  assign push      = in_valid && in_ready && !(bypass && out_ready);

  assign out_data  = out_valid ? head.data : 32'd0;
  assign out_rd    = out_valid ? head.rd   : 5'd0;
  assign fflags    = fflags_q;
  assign count     = cnt_q;

  // Pointers, occupancy and accrued flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      fflags_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      fflags_q <= (fflags_clr ? 5'd0 : fflags_q) | (deq ? head.flags : 5'd0);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_ent;
  end

endmodule

// File: tb/tb_fpu_wb_queue.sv
// Self-checking bench for fpu_wb_queue: directed scenarios plus randomized traffic against a queue model.
module tb_fpu_wb_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, fflags_clr;
  logic [31:0]   in_data, out_data;
  logic [4:0]    in_rd, in_flags, out_rd, fflags;
  logic [CW-1:0] count;

  int passed = 0;
  int total  = 0;

  // Model: each entry is {data[41:10], rd[9:5], flags[4:0]}.
  logic [41:0] mq[$];
  logic [4:0]  mflags;

  fpu_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .fflags(fflags), .fflags_clr(fflags_clr), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] canon(input logic [31:0] d);
    logic is_nan;
    is_nan = (d[30:23] == 8'hFF) && (d[22:0] != 23'd0);
    return is_nan ? 32'h7FC0_0000 : d;
  endfunction

  task automatic idle();
    in_valid = 0; out_ready = 0; fflags_clr = 0;
    in_data = '0; in_rd = '0; in_flags = '0;
  endtask

  task automatic drive_in(input logic [31:0] d, input logic [4:0] rd, input logic [4:0] fl);
    in_valid = 1; in_data = d; in_rd = rd; in_flags = fl;
  endtask

  // Advance one clock edge and update the model from the inputs seen at that edge.
  task automatic cycle();
    bit enq, deq;
    logic [41:0] h;
    h = '0;
    @(posedge clk);
    enq = in_valid && (mq.size() < DEPTH);
    deq = out_ready && (mq.size() > 0);
    if (deq) h = mq[0];
    mflags = (fflags_clr ? 5'd0 : mflags) | (deq ? h[4:0] : 5'd0);
    if (deq) void'(mq.pop_front());
    if (enq) mq.push_back({canon(in_data), in_rd, in_flags});
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    @(negedge clk);
    #1;
    total++;
    if ({out_valid, in_ready, count, fflags, out_data, out_rd} !== {1'b0, 1'b1, CW'(0), 5'd0, 32'd0, 5'd0})
      $display("FAIL reset_state: got v=%b r=%b cnt=%0d ff=%b d=%h rd=%0d", out_valid, in_ready, count, fflags, out_data, out_rd);
    else passed++;
    @(negedge clk);
    rst_n = 1;
    mq.delete(); mflags = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    idle();
    drive_in(32'h4F80_0000, 5'd3, 5'b00001);
    out_ready = 1;
    cycle();
    in_valid = 0;
    #1;
    total++;
    if ({out_valid, out_data, out_rd, fflags} !== {1'b1, 32'h4F80_0000, 5'd3, 5'b00000})
      $display("FAIL basic_out: got v=%b d=%h rd=%0d ff=%b, want v=1 d=4f800000 rd=3 ff=00000", out_valid, out_data, out_rd, fflags);
    else passed++;
    cycle();
    #1;
    total++;
    if ({fflags, out_valid, out_data} !== {5'b00001, 1'b0, 32'd0})
      $display("FAIL basic_flags: got ff=%b v=%b d=%h, want ff=00001 v=0 d=0", fflags, out_valid, out_data);
    else passed++;
  endtask

  task automatic test_fill_drain();
    idle();
    for (int i = 0; i < 5; i++) begin
      drive_in(32'(i + 1), 5'(i + 1), 5'd0);
      #1;
      total++;
      if (in_ready !== (i < 4)) $display("FAIL fill_ready[%0d]: got %b want %b", i, in_ready, (i < 4));
      else passed++;
      cycle();
    end
    in_valid = 0;
    #1;
    total++;
    if ({count, in_ready} !== {CW'(4), 1'b0}) $display("FAIL fill_count: got cnt=%0d r=%b want 4,0", count, in_ready);
    else passed++;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({out_valid, out_data, out_rd} !== {1'b1, 32'(i + 1), 5'(i + 1)})
        $display("FAIL drain[%0d]: got v=%b d=%h rd=%0d want d=%0d", i, out_valid, out_data, out_rd, i + 1);
      else passed++;
      cycle();
    end
    #1;
    total++;
    if (count !== CW'(0)) $display("FAIL drain_empty: got cnt=%0d want 0", count);
    else passed++;
  endtask

  task automatic test_canon();
    logic [31:0] vin [4];
    logic [31:0] vexp [4];
    vin  = '{32'h7FC0_0001, 32'hFF80_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vexp = '{32'h7FC0_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h8000_0000};
    idle();
    for (int i = 0; i < 4; i++) begin
      drive_in(vin[i], 5'(i + 8), 5'd0);
      cycle();
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (out_data !== vexp[i]) $display("FAIL canon[%0d]: in %h got %h want %h", i, vin[i], out_data, vexp[i]);
      else passed++;
      cycle();
    end
  endtask

  task automatic test_full_simul();
    idle();
    for (int i = 0; i < 4; i++) begin
      drive_in(32'h100 + 32'(i), 5'(20 + i), 5'd0);
      cycle();
    end
    drive_in(32'h200, 5'd30, 5'd0);
    out_ready = 1;
    cycle();
    #1;
    total++;
    if ({count, out_data} !== {CW'(3), 32'h101}) $display("FAIL full_deq: got cnt=%0d d=%h want 3,101", count, out_data);
    else passed++;
    drive_in(32'h201, 5'd31, 5'd0);
    cycle();
    #1;
    total++;
    if ({count, out_data} !== {CW'(3), 32'h102}) $display("FAIL full_both: got cnt=%0d d=%h want 3,102", count, out_data);
    else passed++;
    idle(); out_ready = 1;
    while (mq.size() > 0) cycle();
  endtask

  task automatic test_flag_clr();
    idle();
    fflags_clr = 1; cycle(); fflags_clr = 0;
    drive_in(32'h3F80_0000, 5'd1, 5'b00001); out_ready = 1;
    cycle();
    drive_in(32'h4000_0000, 5'd2, 5'b10000);
    cycle();
    in_valid = 0;
    #1;
    total++;
    if (fflags !== 5'b00001) $display("FAIL flag_pre: got %b want 00001", fflags);
    else passed++;
    fflags_clr = 1;
    cycle();
    fflags_clr = 0;
    #1;
    total++;
    if (fflags !== 5'b10000) $display("FAIL flag_clr_deq: got %b want 10000", fflags);
    else passed++;
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 0; i < 3; i++) begin
      drive_in(32'h500 + 32'(i), 5'(i), 5'b00100);
      cycle();
    end
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    total++;
    if ({count, out_valid, fflags, in_ready, out_data} !== {CW'(0), 1'b0, 5'd0, 1'b1, 32'd0})
      $display("FAIL reset_async: got cnt=%0d v=%b ff=%b r=%b d=%h", count, out_valid, fflags, in_ready, out_data);
    else passed++;
    @(negedge clk);
    rst_n = 1;
    mq.delete(); mflags = 0;
    drive_in(32'h600, 5'd7, 5'd0);
    cycle();
    in_valid = 0;
    #1;
    total++;
    if ({count, out_valid, out_data, out_rd} !== {CW'(1), 1'b1, 32'h600, 5'd7})
      $display("FAIL reset_first_enq: got cnt=%0d v=%b d=%h rd=%0d", count, out_valid, out_data, out_rd);
    else passed++;
  endtask

  task automatic test_random();
    logic [CW+43:0] got, exp_v;
    logic [31:0] d;
    for (int n = 0; n < 600; n++) begin
      d = $urandom;
      case ($urandom_range(0, 7))
        0: d = {d[31], 8'hFF, d[22:0]};
        1: d = {d[31], 8'hFF, 23'd0};
        default: ;
      endcase
      in_valid   = ($urandom_range(0, 9) < 6);
      out_ready  = ($urandom_range(0, 9) < ((n / 100) % 2 == 0 ? 7 : 3));
      fflags_clr = ($urandom_range(0, 15) == 0);
      in_data    = d;
      in_rd      = 5'($urandom);
      in_flags   = 5'($urandom);
      #1;
      got   = {out_valid, in_ready, count, fflags, out_data, out_rd};
      exp_v = {mq.size() > 0, mq.size() < DEPTH, CW'(mq.size()), mflags,
               (mq.size() > 0) ? mq[0][41:10] : 32'd0, (mq.size() > 0) ? mq[0][9:5] : 5'd0};
      total++;
      if (got !== exp_v) $display("FAIL random[%0d]: got %h want %h", n, got, exp_v);
      else passed++;
      cycle();
    end
  endtask

  initial begin
    mflags = 0;
    test_reset();
    test_basic();
    test_fill_drain();
    test_canon();
    test_full_simul();
    test_flag_clr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fpu_wb_queue.md
FPU_WB_QUEUE -- requirements
Module: fpu_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4; entry count, power of two, 2..16.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst_n  in  1  async active-low reset.
REQ-004 SHALL have port in_valid  in  1  FPU result (e.g. int-to-float convert) present.
REQ-005 SHALL have port in_ready  out  1  queue can accept.
REQ-006 SHALL have port in_data  in  32  IEEE-754 single result.
REQ-007 SHALL have port in_rd  in  5  destination FP register.
REQ-008 SHALL have port in_flags  in  5  exception flags {NV,DZ,OF,UF,NX}.
REQ-009 SHALL have port out_valid  out  1  write-back entry present.
REQ-010 SHALL have port out_ready  in  1  FP register-file write port free.
REQ-011 SHALL have port out_data  out  32  value to write.
REQ-012 SHALL have port out_rd  out  5  register to write.
REQ-013 SHALL have port fflags  out  5  sticky accrued flags.
REQ-014 SHALL have port fflags_clr  in  1  clear accrued flags (CSR write).
REQ-015 SHALL have port count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL be a FIFO of DEPTH entries {data,rd,flags}; enqueue when in_valid&&in_ready, dequeue when out_valid&&out_ready.
REQ-017 SHALL drive in_ready=1 iff count<DEPTH; no combinational path from out_ready to in_ready.
REQ-018 SHALL drive out_valid=1 iff count>0 (bypass exception in REQ-029); out_data/out_rd from head entry, stable while out_valid&&!out_ready.
REQ-019 SHALL canonicalize on enqueue: any NaN (exp=FF, mantissa!=0) stored as 32'h7FC00000; all other values, including +/-inf and zero, stored unchanged.
REQ-020 SHALL have one-cycle latency: entry enqueued at edge N is visible at out_* after edge N.
REQ-021 SHALL, on simultaneous enqueue and dequeue, keep count unchanged; allowed when full (in_ready=0 means no enqueue; no full pass-through).
REQ-022 SHALL use read/write pointers wrapping modulo DEPTH; count updates +1, -1 or 0 per cycle.
REQ-023 SHALL update fflags next = (fflags_clr ? 0 : fflags) | (dequeue ? head.flags : 0); clear and same-cycle dequeue yields head flags only.
REQ-024 SHALL accrue flags only on dequeue, never on enqueue.
REQ-025 SHALL ignore in_data/in_rd/in_flags when in_valid=0 and hold state when no handshake occurs.

Reset
REQ-026 SHALL, on rst_n=0 at any time, asynchronously clear pointers, count=0, out_valid=0, fflags=0, in_ready=1 (after release); storage contents need not be cleared.
REQ-027 SHALL drop all in-flight entries on reset mid-operation; first post-reset edge with in_valid=1 enqueues normally.
REQ-028 SHALL drive out_data=0, out_rd=0 while out_valid=0.

Configuration
REQ-029 SHALL, with FPU_WB_BYPASS_EN defined, present in_* combinationally at out_* when count=0 and in_valid=1 (out_valid=1, zero latency); if out_ready=1 that cycle the entry is consumed and not stored, flags accrued per REQ-023.
REQ-030 SHALL, without FPU_WB_BYPASS_EN, have no in-to-out combinational path; latency exactly one cycle per REQ-020.

Verification
REQ-031 SHALL cover: reset, enqueue in_data=32'h4F800000 rd=3 flags=5'b00001, out_ready=1 -> next cycle out_data=32'h4F800000 out_rd=3, fflags=5'b00001 after dequeue edge.
REQ-032 SHALL cover: DEPTH=4, out_ready=0, 5 back-to-back valids -> in_ready=0 after 4th, count=4, 5th not accepted; then drain returns entries 1..4 in order.
REQ-033 SHALL cover: in_data=32'h7FC00001 -> out_data=32'h7FC00000; in_data=32'hFF800000 -> out_data=32'hFF800000.
REQ-034 SHALL cover: full queue, in_valid=1, out_ready=1 -> one dequeue, no enqueue, count=3; next cycle enqueue accepted, count stays 3.
REQ-035 SHALL cover: fflags=5'b00001, fflags_clr=1 with dequeue of flags=5'b10000 -> fflags=5'b10000.
REQ-036 SHALL cover: rst_n low with 3 entries queued -> count=0, out_valid=0, fflags=0 immediately, before next clk edge.
